// File: rtl/vending_pkg.sv
// Shared vending-machine types and constants: item numbers, default prices.
package vending_pkg;

    typedef logic [7:0] price_t;
    typedef logic [3:0] item_t;

    localparam item_t ITEM_NONE = 4'd0;
    localparam item_t ITEM1     = 4'd1;
    localparam item_t ITEM2     = 4'd2;
    localparam item_t ITEM3     = 4'd3;
    localparam item_t ITEM4     = 4'd4;

    localparam price_t DEF_PRICE1 = 8'd25;
    localparam price_t DEF_PRICE2 = 8'd50;
    localparam price_t DEF_PRICE3 = 8'd100;
    localparam price_t DEF_PRICE4 = 8'd150;

endpackage

// File: rtl/price_rom.sv
// Combinational item-number to unit-price lookup; unknown items cost 0.
module price_rom
    import vending_pkg::*;
#(
    parameter price_t PRICE1 = DEF_PRICE1,
    parameter price_t PRICE2 = DEF_PRICE2,
    parameter price_t PRICE3 = DEF_PRICE3,
    parameter price_t PRICE4 = DEF_PRICE4
) (
    input  item_t  item_i,
    output price_t price_o
);

    always_comb begin
        price_o = '0;
        case (item_i)
            ITEM1:   price_o = PRICE1;
            ITEM2:   price_o = PRICE2;
            ITEM3:   price_o = PRICE3;
            ITEM4:   price_o = PRICE4;
            default: price_o = '0;
        endcase
    end

endmodule

// File: rtl/choose_commodity.sv
// Commodity selection: one-hot button decode, registered item number and price.
// Define CHOOSE_HOLD_EN to keep the last selection while no button is pressed.
module choose_commodity
    import vending_pkg::*;
#(
    parameter price_t PRICE1 = DEF_PRICE1,
    parameter price_t PRICE2 = DEF_PRICE2,
    parameter price_t PRICE3 = DEF_PRICE3,
    parameter price_t PRICE4 = DEF_PRICE4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] goods,
    output logic [7:0] goods_price,
    output logic [3:0] goods_num
);

    logic   onehot;
    logic   hold;
    item_t  item_d, item_q;
    price_t price_d, price_q;

    // Exactly one bit set; multi-hot and zero both fall out as invalid.
    assign onehot = (goods != 4'd0) && ((goods & (goods - 4'd1)) == 4'd0);

    always_comb begin
        item_d = ITEM_NONE;
        if (onehot) begin
            for (int i = 0; i < 4; i++) begin
                if (goods[i]) item_d = item_t'(i + 1);
            end
        end
    end

    always_comb begin
`ifdef CHOOSE_HOLD_EN
        hold = (goods == 4'd0);
`else
        hold = 1'b0;
`endif
    end

    price_rom #(
        .PRICE1 (PRICE1),
        .PRICE2 (PRICE2),
        .PRICE3 (PRICE3),
        .PRICE4 (PRICE4)
    ) u_price_rom (
        .item_i  (item_d),
        .price_o (price_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            item_q  <= ITEM_NONE;
            price_q <= '0;
        end else if (!hold) begin
            item_q  <= item_d;
            price_q <= price_d;
        end
    end

    assign goods_num   = item_q;
    assign goods_price = price_q;

endmodule

// File: tb/tb_choose_commodity.sv
// Bench for choose_commodity: directed table, sub-cycle glitch sequences, random vs. model.
module tb_choose_commodity;

`ifdef CHOOSE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] goods = 4'd0;
    logic [7:0] goods_price;
    logic [3:0] goods_num;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_num   = 4'd0;
    logic [7:0] m_price = 8'd0;

    typedef struct {
        logic       rst;
        logic [3:0] goods;
        logic [3:0] num;
        logic [7:0] price;
    } vec_t;

    vec_t vecs[20];

    choose_commodity dut (
        .clk         (clk),
        .rst         (rst),
        .goods       (goods),
        .goods_price (goods_price),
        .goods_num   (goods_num)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] price_of(input int item);
        case (item)
            1: return 8'd25;
            2: return 8'd50;
            3: return 8'd100;
            4: return 8'd150;
            default: return 8'd0;
        endcase
    endfunction

    // Reference: what the registers should hold after an edge sampling (r, g).
    task automatic model(input logic r, input logic [3:0] g);
        if (!r) begin
            m_num = 0; m_price = 0;
        end else if ($countones(g) == 1) begin
            for (int i = 0; i < 4; i++)
                if (g[i]) begin m_num = 4'(i + 1); m_price = price_of(i + 1); end
        end else if (g == 4'd0 && HOLD) begin
            // selection kept
        end else begin
            m_num = 0; m_price = 0;
        end
    endtask

    task automatic check(input string name, input logic [3:0] en, input logic [7:0] ep);
        checks++;
        if (goods_num !== en || goods_price !== ep) begin
            errors++;
            $display("FAIL %s: got num=%0d price=%0d, want num=%0d price=%0d",
                     name, goods_num, goods_price, en, ep);
        end
    endtask

    // Drive at the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic r, input logic [3:0] g);
        @(negedge clk);
        rst = r; goods = g;
        @(posedge clk);
        model(r, g);
        #1;
    endtask

    // Base value at the edge, with a 10ns pulse of another value mid-phase.
    task automatic glitch_step(input logic [3:0] base, input logic [3:0] pulse);
        @(negedge clk);
        rst = 1'b1; goods = base;
        #4  goods = pulse;
        #10 goods = base;
        @(posedge clk);
        model(1'b1, base);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] g,
                                input logic [3:0] n, input logic [7:0] p);
        vec_t v;
        v.rst = r; v.goods = g; v.num = n; v.price = p;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(0, 4'b1000, 0, 0);
        vecs[1]  = mk(0, 4'b1000, 0, 0);
        vecs[2]  = mk(1, 4'b1000, 4, 150);
        vecs[3]  = mk(1, 4'b0001, 1, 25);
        vecs[4]  = mk(1, 4'b0100, 3, 100);
        vecs[5]  = mk(1, 4'b0010, 2, 50);
        vecs[6]  = mk(1, 4'b0001, 1, 25);
        vecs[7]  = mk(1, 4'b1001, 0, 0);
        vecs[8]  = mk(1, 4'b0001, 1, 25);
        vecs[9]  = mk(1, 4'b0110, 0, 0);
        vecs[10] = mk(1, 4'b1111, 0, 0);
        vecs[11] = mk(1, 4'b0100, 3, 100);
        vecs[12] = mk(1, 4'b0000, HOLD ? 4'd3 : 4'd0, HOLD ? 8'd100 : 8'd0);
        vecs[13] = mk(1, 4'b0000, HOLD ? 4'd3 : 4'd0, HOLD ? 8'd100 : 8'd0);
        vecs[14] = mk(0, 4'b0010, 0, 0);
        vecs[15] = mk(1, 4'b0010, 2, 50);
        vecs[16] = mk(1, 4'b0000, HOLD ? 4'd2 : 4'd0, HOLD ? 8'd50 : 8'd0);
        vecs[17] = mk(1, 4'b1000, 4, 150);
        vecs[18] = mk(1, 4'b1100, 0, 0);
        vecs[19] = mk(1, 4'b0000, 0, 0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].goods);
            check($sformatf("vec%0d", i), vecs[i].num, vecs[i].price);
        end

        glitch_step(4'b1000, 4'b0001);
        check("glitch_1000_0001", 4'd4, 8'd150);
        glitch_step(4'b0001, 4'b0100);
        check("glitch_0001_0100", 4'd1, 8'd25);
        glitch_step(4'b0010, 4'b0000);
        check("glitch_0010_0000", 4'd2, 8'd50);

        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [3:0] g;
            r = ($urandom_range(0, 15) != 0);
            case ($urandom_range(0, 3))
                0:       g = 4'd0;
                1:       g = 4'(1 << $urandom_range(0, 3));
                2:       g = 4'(1 << $urandom_range(0, 3));
                default: g = 4'($urandom_range(0, 15));
            endcase
            step(r, g);
            check($sformatf("rand%0d_r%0d_g%b", i, r, g), m_num, m_price);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
